// File: rtl/puf_host_link.sv
// puf_host_link: host bridge that serialises a PUF challenge to the SoC and
// deserialises normal or debug+normal response frames back to the host.
module puf_host_link #(
  parameter int REG_BIT_SIZE = 40,
  parameter int NORM_MOD     = 34,
  parameter int DEBUG_MOD    = 157,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_chal_valid,
  input  logic [REG_BIT_SIZE-1:0] i_chal_data,
  input  logic                    i_dbg_mode,
  output logic                    o_chal_ready,
  output logic                    o_soc_start,
  output logic                    o_soc_op_mode,
  input  logic                    i_soc_rx_ready,
  output logic                    o_soc_rx_valid,
  output logic                    o_soc_rx_data,
  input  logic                    i_soc_tx_valid,
  input  logic                    i_soc_tx_data,
  output logic                    o_soc_tx_ready,
  output logic                    o_resp_valid,
  output logic [DEBUG_MOD-1:0]    o_resp_data,
  output logic                    o_resp_dbg,
  input  logic                    i_resp_ready,
  output logic                    o_err,
  output logic                    o_busy
);
  localparam int BW = $clog2(REG_BIT_SIZE);
  localparam int RW = $clog2(DEBUG_MOD + 1);
  localparam int GW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND, RECV, HOLD, PULSE} state_t;
  state_t state_q, state_d;
  logic [REG_BIT_SIZE-1:0] chal_q, chal_d;
  logic [DEBUG_MOD-1:0] resp_q, resp_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RW-1:0] rx_q, rx_d, exp_len;
  logic [GW-1:0] gap_q, gap_d;
  logic dbg_q, dbg_d, timeout;
  logic chal_ready_q, chal_ready_d, start_q, start_d, op_mode_q, op_mode_d;
  logic rx_valid_q, rx_valid_d, rx_data_q, rx_data_d, tx_ready_q, tx_ready_d;
  logic resp_valid_q, resp_valid_d, resp_dbg_q, resp_dbg_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    dbg_d   = dbg_q;
    exp_len = dbg_q ? RW'(DEBUG_MOD) : RW'(NORM_MOD);
    gap_d   = (state_q == RECV && !i_soc_tx_valid) ? gap_q + GW'(1) : '0;
    timeout = state_q == RECV && gap_d == GW'(TIMEOUT);
    case (state_q)
      IDLE: if (i_chal_valid) begin
        chal_d  = i_chal_data;
        dbg_d   = i_dbg_mode;
        bit_d   = '0;
        state_d = SEND;
      end
      SEND: if (i_soc_rx_ready) begin
        if (bit_q == BW'(REG_BIT_SIZE - 1)) begin
          bit_d   = '0;
          rx_d    = '0;
          resp_d  = '0;
          state_d = RECV;
        end else bit_d = bit_q + BW'(1);
      end
      RECV: if (timeout) begin
        // a stalled partial frame is dropped rather than presented
        resp_d  = '0;
        rx_d    = '0;
        state_d = IDLE;
      end else if (i_soc_tx_valid) begin
        resp_d[rx_q] = i_soc_tx_data;
        rx_d = rx_q + RW'(1);
        if (rx_q == exp_len - RW'(1)) begin
          rx_d    = '0;
          state_d = HOLD;
        end
      end
      HOLD: if (i_resp_ready) state_d = dbg_q ? PULSE : IDLE;
      PULSE: begin
        dbg_d   = 1'b0;
        resp_d  = '0;
        rx_d    = '0;
        state_d = RECV;
      end
      default: state_d = IDLE;
    endcase
    chal_ready_d = state_d == IDLE;
    start_d      = state_d != IDLE;
    op_mode_d    = state_d == PULSE;
    rx_valid_d   = state_d == SEND;
    rx_data_d    = state_d == SEND && chal_d[bit_d];
    tx_ready_d   = state_d == RECV;
    resp_valid_d = state_d == HOLD;
    resp_dbg_d   = state_d == HOLD && dbg_d;
    err_d        = timeout;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chal_q       <= '0;
      resp_q       <= '0;
      bit_q        <= '0;
      rx_q         <= '0;
      gap_q        <= '0;
      dbg_q        <= 1'b0;
      chal_ready_q <= 1'b1;
      start_q      <= 1'b0;
      op_mode_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 1'b0;
      tx_ready_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_dbg_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      bit_q        <= bit_d;
      rx_q         <= rx_d;
      gap_q        <= gap_d;
      dbg_q        <= dbg_d;
      chal_ready_q <= chal_ready_d;
      start_q      <= start_d;
      op_mode_q    <= op_mode_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      tx_ready_q   <= tx_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_dbg_q   <= resp_dbg_d;
      err_q        <= err_d;
    end
  end
  assign o_chal_ready   = chal_ready_q;
  assign o_soc_start    = start_q;
  assign o_soc_op_mode  = op_mode_q;
  assign o_soc_rx_valid = rx_valid_q;
  assign o_soc_rx_data  = rx_data_q;
  assign o_soc_tx_ready = tx_ready_q;
  assign o_resp_valid   = resp_valid_q;
  assign o_resp_data    = resp_q;
  assign o_resp_dbg     = resp_dbg_q;
  assign o_err          = err_q;
  assign o_busy         = start_q;
endmodule

// File: tb/tb_puf_host_link.sv
// tb_puf_host_link: directed + randomized transactions against a bit-list model
// of the challenge/response link.
module tb_puf_host_link;
  localparam int W = 40, NM = 34, DM = 157, TO = 4096;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_chal_valid = 1'b0, i_dbg_mode = 1'b0, i_soc_rx_ready = 1'b0;
  logic i_soc_tx_valid = 1'b0, i_soc_tx_data = 1'b0, i_resp_ready = 1'b0;
  logic [W-1:0] i_chal_data = '0;
  logic o_chal_ready, o_soc_start, o_soc_op_mode, o_soc_rx_valid, o_soc_rx_data;
  logic o_soc_tx_ready, o_resp_valid, o_resp_dbg, o_err, o_busy;
  logic [DM-1:0] o_resp_data;
  int checks = 0, failures = 0;

  puf_host_link dut (
    .clk(clk), .rst_n(rst_n), .i_chal_valid(i_chal_valid), .i_chal_data(i_chal_data),
    .i_dbg_mode(i_dbg_mode), .o_chal_ready(o_chal_ready), .o_soc_start(o_soc_start),
    .o_soc_op_mode(o_soc_op_mode), .i_soc_rx_ready(i_soc_rx_ready), .o_soc_rx_valid(o_soc_rx_valid),
    .o_soc_rx_data(o_soc_rx_data), .i_soc_tx_valid(i_soc_tx_valid), .i_soc_tx_data(i_soc_tx_data),
    .o_soc_tx_ready(o_soc_tx_ready), .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data),
    .o_resp_dbg(o_resp_dbg), .i_resp_ready(i_resp_ready), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DM-1:0] obs, input logic [DM-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, DM'({o_chal_ready, o_soc_start, o_soc_op_mode, o_soc_rx_valid, o_soc_rx_data,
                  o_soc_tx_ready, o_resp_valid, o_resp_dbg, o_err, o_busy}), DM'(10'b10_0000_0000));
    chk({tag, "_data"}, o_resp_data, '0);
  endtask

  function automatic logic [DM-1:0] rand_frame();
    logic [DM-1:0] f;
    for (int i = 0; i < DM; i++) f[i] = 1'($urandom);
    return f;
  endfunction

  // Offer a challenge, then play the SoC receiver; the model is simply "the bits
  // accepted, in order, must spell the challenge LSB first".
  task automatic send(input logic [W-1:0] ch, input logic dbg, input int stall_bit,
                      input int stall_len, input int abort_at);
    logic [W-1:0] got;
    logic rdy;
    int k, len, rem, cyc;
    got = '0; k = 0; len = 0; rem = stall_len; cyc = 0;
    i_chal_valid = 1'b1; i_chal_data = ch; i_dbg_mode = dbg;
    tick;
    i_chal_valid = 1'b0; i_chal_data = W'({$urandom, $urandom}); i_dbg_mode = 1'($urandom);
    chk("accept", DM'({o_chal_ready, o_soc_start, o_busy, o_soc_rx_valid}), DM'(4'b0111));
    while (k < W && cyc < 4 * W && k != abort_at) begin
      rdy = (k == stall_bit && rem > 0) ? 1'b0 : 1'b1;
      if (!rdy) begin
        rem--;
        chk("stall_hold", DM'({o_soc_rx_valid, o_soc_rx_data}), DM'({1'b1, ch[k]}));
      end
      i_soc_rx_ready = rdy;
      if (o_soc_rx_valid) len++;
      if (o_soc_rx_valid && rdy) begin
        got[k] = o_soc_rx_data;
        k++;
      end
      cyc++;
      tick;
    end
    i_soc_rx_ready = 1'b0;
    if (abort_at < 0) begin
      chk("send_bits", DM'(got), DM'(ch));
      chk("send_len", DM'(len), DM'(W + stall_len));
      chk("send_done", DM'({o_soc_rx_valid, o_soc_tx_ready, o_soc_start}), DM'(3'b011));
    end
  endtask

  // Play the SoC transmitter with random gaps, then check the held frame.
  task automatic recv(input logic [DM-1:0] fr, input int n, input logic dbg, input int hold);
    logic [DM-1:0] want;
    want = '0;
    chk("tx_ready", DM'({o_soc_tx_ready, o_resp_valid}), DM'(2'b10));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        i_soc_tx_valid = 1'b0; i_soc_tx_data = 1'($urandom);
        tick;
      end
      i_soc_tx_valid = 1'b1; i_soc_tx_data = fr[i]; want[i] = fr[i];
      tick;
    end
    i_soc_tx_valid = 1'b0;
    chk("resp_flags", DM'({o_resp_valid, o_resp_dbg, o_soc_tx_ready}), DM'({1'b1, dbg, 1'b0}));
    chk("resp_data", o_resp_data, want);
    repeat (hold) begin
      i_soc_tx_valid = 1'($urandom); i_soc_tx_data = 1'($urandom);
      tick;
    end
    i_soc_tx_valid = 1'b0;
    chk("hold_flags", DM'({o_resp_valid, o_resp_dbg, o_soc_tx_ready}), DM'({1'b1, dbg, 1'b0}));
    chk("hold_data", o_resp_data, want);
    i_resp_ready = 1'b1;
    tick;
    i_resp_ready = 1'b0;
    if (dbg) begin
      chk("op_pulse", DM'({o_soc_op_mode, o_resp_valid, o_soc_start}), DM'(3'b101));
      tick;
      chk("op_drop", DM'({o_soc_op_mode, o_soc_tx_ready}), DM'(2'b01));
    end else
      chk("back_idle", DM'({o_chal_ready, o_busy, o_soc_start, o_resp_valid}), DM'(4'b1000));
  endtask

  task automatic transaction(input logic [W-1:0] ch, input logic dbg, input int stall_bit,
                             input int stall_len, input int hold);
    send(ch, dbg, stall_bit, stall_len, -1);
    if (dbg) recv(rand_frame(), DM, 1'b1, hold);
    recv(rand_frame(), NM, 1'b0, hold);
  endtask

  initial begin
    int n;
    logic seen;
    repeat (2) tick;
    chk_reset("reset");
    rst_n = 1'b1;
    transaction({32'd1024, 4'b1000, 4'b0001}, 1'b0, -1, 0, 0);
    transaction(W'({$urandom, $urandom}), 1'b0, 10, 5, 50);
    transaction(W'({$urandom, $urandom}), 1'b1, -1, 0, 3);
    for (int t = 0; t < 4; t++)
      transaction(W'({$urandom, $urandom}), 1'($urandom), $urandom_range(0, W - 1),
                  $urandom_range(0, 4), $urandom_range(0, 6));
    send(W'({$urandom, $urandom}), 1'b0, -1, 0, -1);
    for (int i = 0; i < 20; i++) begin
      i_soc_tx_valid = 1'b1; i_soc_tx_data = 1'($urandom);
      tick;
    end
    i_soc_tx_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!o_err && n < TO + 10) begin
      tick;
      n++;
      if (o_resp_valid) seen = 1'b1;
    end
    chk("timeout_cycles", DM'(n), DM'(TO));
    chk("timeout_state", DM'({o_chal_ready, o_resp_valid, o_busy, seen}), DM'(4'b1000));
    chk("timeout_discard", o_resp_data, '0);
    tick;
    chk("err_one_cycle", DM'(o_err), '0);
    transaction(W'({$urandom, $urandom}), 1'b0, -1, 0, 0);
    send(W'({$urandom, $urandom}), 1'b0, -1, 0, 15);
    chk("mid_send", DM'({o_soc_rx_valid, o_soc_start}), DM'(2'b11));
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    tick;
    rst_n = 1'b1;
    transaction(W'({$urandom, $urandom}), 1'b1, 3, 2, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/puf_host_link.md
PUF_HOST_LINK -- requirements
Module: puf_host_link

Interface
REQ-001 Parameters SHALL be: REG_BIT_SIZE, default 40, challenge frame length in bits.
REQ-002 NORM_MOD, default 34, normal response length in bits; DEBUG_MOD, default 157, debug response length in bits.
REQ-003 TIMEOUT, default 4096, maximum idle cycles allowed between response bits.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_chal_valid  input  1  host challenge request; i_chal_data  input  REG_BIT_SIZE  challenge frame.
REQ-007 i_dbg_mode  input  1  debug request, sampled with the challenge; o_chal_ready  output  1  challenge accept.
REQ-008 o_soc_start  output  1  SoC start; o_soc_op_mode  output  1  SoC op-mode pulse.
REQ-009 i_soc_rx_ready  input  1; o_soc_rx_valid  output  1; o_soc_rx_data  output  1  serial challenge link to the SoC.
REQ-010 i_soc_tx_valid  input  1; i_soc_tx_data  input  1; o_soc_tx_ready  output  1  serial response link from the SoC.
REQ-011 o_resp_valid  output  1; o_resp_data  output  DEBUG_MOD; o_resp_dbg  output  1  debug-frame flag; i_resp_ready  input  1  parallel response handshake.
REQ-012 o_err  output  1  one-cycle timeout pulse; o_busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SEND, RECV, HOLD, PULSE.
REQ-014 o_chal_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, i_chal_valid SHALL latch i_chal_data and i_dbg_mode, then move to SEND on the next cycle.
REQ-016 SEND: o_soc_rx_valid=1 and o_soc_rx_data=challenge[bit_idx], LSB first.
REQ-017 SEND: bit_idx SHALL advance only in cycles with i_soc_rx_ready=1; while ready=0, valid and data SHALL hold.
REQ-018 SEND: after bit REG_BIT_SIZE-1 is accepted, valid SHALL drop and the FSM SHALL enter RECV.
REQ-019 o_soc_start SHALL rise on entry to SEND and stay high until return to IDLE.
REQ-020 RECV: o_soc_tx_ready=1; each cycle with i_soc_tx_valid=1 SHALL write i_soc_tx_data to o_resp_data[rx_cnt] and increment rx_cnt.
REQ-021 RECV: expected length SHALL be DEBUG_MOD in the debug phase, otherwise NORM_MOD.
REQ-022 RECV: when rx_cnt reaches the expected length, the FSM SHALL go to HOLD; unused upper bits of o_resp_data SHALL be 0.
REQ-023 HOLD: o_resp_valid=1, o_soc_tx_ready=0, data stable; o_resp_dbg=1 for the debug frame, 0 for a normal frame.
REQ-024 HOLD with i_resp_ready=1 after a debug frame SHALL go to PULSE; after a normal frame, to IDLE.
REQ-025 PULSE SHALL drive o_soc_op_mode=1 for exactly one cycle, then enter RECV expecting NORM_MOD bits, non-debug.
REQ-026 A normal-mode transaction SHALL yield one response; a debug-mode transaction SHALL yield one DEBUG_MOD frame, then one NORM_MOD frame.
REQ-027 Gap counter SHALL clear on every accepted response bit and on entry to RECV, and count every other RECV cycle.
REQ-028 When the gap counter reaches TIMEOUT, the FSM SHALL go to IDLE, pulse o_err for 1 cycle and discard the partial frame.
REQ-029 i_soc_tx_valid outside RECV SHALL be ignored.
REQ-030 i_chal_valid outside IDLE SHALL be ignored.
REQ-031 Counters SHALL be sized by $clog2 of their maximum and SHALL never wrap.

Reset
REQ-032 On rst_n=0, the FSM SHALL enter IDLE asynchronously, mid-transaction included.
REQ-033 On reset, all outputs SHALL be 0 except o_chal_ready=1, and all counters and buffers SHALL clear.
REQ-034 After reset release, the first challenge SHALL be accepted on the first rising edge with i_chal_valid=1.

Verification
REQ-035 Normal: challenge {32'd1024,4'b1000,4'b0001}, rx_ready=1 -> o_soc_rx_data emits 1,0,0,0,0,0,0,1,... over 40 cycles; after 34 response bits, o_resp_valid=1, o_resp_dbg=0.
REQ-036 Backpressure: rx_ready low for 5 cycles at bit 10 -> bit 10 held 6 cycles, total SEND length 45 cycles, frame intact.
REQ-037 Debug: i_dbg_mode=1 -> 157-bit frame with o_resp_dbg=1; after i_resp_ready, one-cycle o_soc_op_mode; then 34-bit frame with o_resp_dbg=0; then IDLE.
REQ-038 Timeout: response stalls after 20 bits -> o_err pulses once TIMEOUT cycles after the last bit; o_resp_valid never asserts; o_chal_ready=1.
REQ-039 Reset mid-SEND at bit 15 -> all outputs at reset values immediately; the next challenge sends from bit 0.
REQ-040 Response hold: i_resp_ready=0 for 50 cycles -> o_resp_data stable; o_soc_tx_ready=0; toggling i_soc_tx_valid has no effect.
